// File: rtl/obi_pkg.sv
// Shared OBI request/response bundles used by masters, slaves and interconnect.
package obi_pkg;

  localparam int unsigned ObiAddrW = 32;
  localparam int unsigned ObiDataW = 32;

  typedef struct packed {
    logic                  req;
    logic [ObiAddrW-1:0]   addr;
    logic                  we;
    logic [ObiDataW/8-1:0] be;
    logic [ObiDataW-1:0]   wdata;
  } obi_req_t;

  typedef struct packed {
    logic                gnt;
    logic                rvalid;
    logic [ObiDataW-1:0] rdata;
  } obi_resp_t;

endpackage

// File: rtl/ext_cpu_obi_id_fifo.sv
// Synchronous FIFO holding requester IDs of outstanding OBI transactions.
// A push while full is accepted only when a pop happens in the same cycle.
module ext_cpu_obi_id_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 2,
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Next-state for storage, pointers (wrapping mod DEPTH) and occupancy.
  always_comb begin
    do_push  = push_i && (!full_o || pop_i);
    do_pop   = pop_i && !empty_o;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = data_i;
      wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // State registers with synchronous flush.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/ext_cpu_obi_arbiter.sv
// Round-robin arbiter sharing one downstream OBI port among NUM_REQ masters.
// Outstanding requester IDs are queued so responses return to their issuer.
module ext_cpu_obi_arbiter
  import obi_pkg::*;
#(
  parameter int unsigned NUM_REQ         = 3,
  parameter int unsigned MAX_OUTSTANDING = 2,
  localparam int unsigned IDX_W = $clog2(NUM_REQ),
  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  obi_req_t  [NUM_REQ-1:0]  req_i,
  output obi_resp_t [NUM_REQ-1:0]  resp_o,
  output obi_req_t                 req_o,
  input  obi_resp_t                resp_i,
  output logic      [CNT_W-1:0]    outstanding_o,
  output logic                     err_o
);

  typedef enum logic {StIdle, StLocked} state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0] locked_idx_q, locked_idx_d;
  logic             err_q, err_d;

  logic [IDX_W-1:0] scan_idx, sel;
  logic             any_req, req_valid, handshake;
  logic             fifo_full, fifo_empty, full_gate;
  logic [IDX_W-1:0] fifo_head;

  // A pop in the same cycle frees a slot, so a full FIFO may still accept.
  assign full_gate = fifo_full && !resp_i.rvalid;

  // Round-robin scan starting at rr_ptr, wrapping mod NUM_REQ.
  always_comb begin
    int unsigned      cand;
    logic [IDX_W-1:0] cand_idx;
    any_req  = 1'b0;
    scan_idx = '0;
    cand     = 0;
    cand_idx = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand     = (int'(rr_ptr_q) + i) % NUM_REQ;
      cand_idx = IDX_W'(cand);
      if (!any_req && req_i[cand_idx].req) begin
        any_req  = 1'b1;
        scan_idx = cand_idx;
      end
    end
  end

  // Downstream request mux and per-requester response routing.
  always_comb begin
    sel       = (state_q == StLocked) ? locked_idx_q : scan_idx;
    req_valid = ((state_q == StLocked) || any_req) && !full_gate;
    handshake = req_valid && resp_i.gnt;
    req_o     = req_i[sel];
    req_o.req = req_valid;
    resp_o    = '0;
    for (int k = 0; k < int'(NUM_REQ); k++) begin
      resp_o[k].gnt    = handshake && (sel == IDX_W'(k));
      resp_o[k].rvalid = resp_i.rvalid && !fifo_empty && (fifo_head == IDX_W'(k));
      resp_o[k].rdata  = resp_i.rdata;
    end
  end

  // Lock FSM, round-robin pointer update and sticky error detection.
  always_comb begin
    state_d      = state_q;
    locked_idx_d = locked_idx_q;
    rr_ptr_d     = rr_ptr_q;
    err_d        = err_q || (resp_i.rvalid && fifo_empty);
    unique case (state_q)
      StIdle: begin
        if (req_valid && !resp_i.gnt) begin
          state_d      = StLocked;
          locked_idx_d = sel;
        end
      end
      StLocked: begin
        if (handshake) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (handshake) begin
      rr_ptr_d = (sel == IDX_W'(NUM_REQ - 1)) ? '0 : sel + 1'b1;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      rr_ptr_q     <= '0;
      locked_idx_q <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      locked_idx_q <= locked_idx_d;
      err_q        <= err_d;
    end
  end

  assign err_o = err_q;

  ext_cpu_obi_id_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (IDX_W)
  ) u_id_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (handshake),
    .data_i  (sel),
    .pop_i   (resp_i.rvalid),
    .head_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (outstanding_o)
  );

endmodule

// File: tb/tb_ext_cpu_obi_arbiter.sv
// Self-checking bench for ext_cpu_obi_arbiter: directed scenarios plus a
// randomized run against a queue-based reference model.
module tb_ext_cpu_obi_arbiter;
  import obi_pkg::*;

  localparam int N  = 3;
  localparam int MO = 2;

  logic                clk = 1'b0;
  logic                rst;
  obi_req_t  [N-1:0]   req_i;
  obi_resp_t [N-1:0]   resp_o;
  obi_req_t            req_o;
  obi_resp_t           resp_i;
  logic      [1:0]     outstanding;
  logic                err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ext_cpu_obi_arbiter #(
    .NUM_REQ         (N),
    .MAX_OUTSTANDING (MO)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .req_i         (req_i),
    .resp_o        (resp_o),
    .req_o         (req_o),
    .resp_i        (resp_i),
    .outstanding_o (outstanding),
    .err_o         (err)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req_i  = '0;
    resp_i = '0;
  endtask

  task automatic set_req(input int k, input logic [31:0] a, input logic [31:0] d);
    req_i[k].req   = 1'b1;
    req_i[k].addr  = a;
    req_i[k].we    = d[0];
    req_i[k].be    = d[7:4];
    req_i[k].wdata = d;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    tick();
    tick();
    rst = 1'b0;
  endtask

  function automatic logic [N-1:0] gnts();
    logic [N-1:0] v;
    for (int k = 0; k < N; k++) v[k] = resp_o[k].gnt;
    return v;
  endfunction

  function automatic logic [N-1:0] rvs();
    logic [N-1:0] v;
    for (int k = 0; k < N; k++) v[k] = resp_o[k].rvalid;
    return v;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    tick();
    tick();
    checks++; if (req_o.req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", req_o.req); end
    checks++; if (outstanding !== 2'd0) begin errors++; $display("FAIL reset_outstanding: got %0d want 0", outstanding); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err); end
    checks++; if ((gnts() | rvs()) !== '0) begin errors++; $display("FAIL reset_resp: gnt %b rvalid %b want 0", gnts(), rvs()); end
    rst = 1'b0;
  endtask

  task automatic test_single();
    logic [31:0] d, r, a2;
    do_reset();
    d  = $urandom;
    r  = $urandom;
    a2 = $urandom;
    set_req(1, 32'h2000_0100, d);
    resp_i.gnt = 1'b1;
    #1;
    checks++; if (req_o.req !== 1'b1) begin errors++; $display("FAIL single_req: got %b want 1", req_o.req); end
    checks++; if (req_o.addr !== 32'h2000_0100) begin errors++; $display("FAIL single_addr: got %h want 20000100", req_o.addr); end
    checks++; if (req_o.wdata !== d) begin errors++; $display("FAIL single_wdata: got %h want %h", req_o.wdata, d); end
    checks++; if (gnts() !== 3'b010) begin errors++; $display("FAIL single_gnt: got %b want 010", gnts()); end
    tick();
    req_i[1].req  = 1'b0;
    resp_i.gnt    = 1'b0;
    resp_i.rvalid = 1'b1;
    resp_i.rdata  = r;
    #1;
    checks++; if (rvs() !== 3'b010) begin errors++; $display("FAIL single_rvalid: got %b want 010", rvs()); end
    checks++; if (resp_o[1].rdata !== r) begin errors++; $display("FAIL single_rdata: got %h want %h", resp_o[1].rdata, r); end
    checks++; if (outstanding !== 2'd1) begin errors++; $display("FAIL single_outst: got %0d want 1", outstanding); end
    tick();
    resp_i.rvalid = 1'b0;
    set_req(0, 32'h0000_0040, $urandom);
    set_req(2, a2, $urandom);
    resp_i.gnt = 1'b1;
    #1;
    // rr_ptr should now be 2, so requester 2 wins over 0.
    checks++; if (gnts() !== 3'b100) begin errors++; $display("FAIL single_rrptr_gnt: got %b want 100", gnts()); end
    checks++; if (req_o.addr !== a2) begin errors++; $display("FAIL single_rrptr_addr: got %h want %h", req_o.addr, a2); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL single_err: got %b want 0", err); end
    tick();
    idle_inputs();
  endtask

  task automatic test_rotate();
    do_reset();
    for (int k = 0; k < N; k++) set_req(k, 32'h1000_0000 + 32'(k * 16), $urandom);
    resp_i.gnt = 1'b1;
    for (int i = 0; i < 7; i++) begin
      resp_i.rvalid = (i > 0);
      resp_i.rdata  = $urandom;
      if (i == 6) req_i = '0;
      #1;
      if (i < 6) begin
        checks++; if (gnts() !== 3'(1 << (i % 3))) begin errors++; $display("FAIL rotate_gnt[%0d]: got %b want %b", i, gnts(), 3'(1 << (i % 3))); end
        checks++; if (req_o.addr !== 32'h1000_0000 + 32'((i % 3) * 16)) begin errors++; $display("FAIL rotate_addr[%0d]: got %h", i, req_o.addr); end
      end
      if (i > 0) begin
        checks++; if (rvs() !== 3'(1 << ((i - 1) % 3))) begin errors++; $display("FAIL rotate_rvalid[%0d]: got %b want %b", i, rvs(), 3'(1 << ((i - 1) % 3))); end
      end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_stall();
    logic [31:0] a0, d0, a2;
    do_reset();
    a0 = $urandom;
    d0 = $urandom;
    a2 = $urandom;
    set_req(0, a0, d0);
    set_req(2, a2, $urandom);
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if (req_o.req !== 1'b1 || req_o.addr !== a0 || req_o.wdata !== d0) begin
        errors++; $display("FAIL stall_hold[%0d]: req %b addr %h wdata %h want 1 %h %h", c, req_o.req, req_o.addr, req_o.wdata, a0, d0);
      end
      checks++; if (gnts() !== 3'b000) begin errors++; $display("FAIL stall_nognt[%0d]: got %b want 000", c, gnts()); end
      tick();
    end
    resp_i.gnt = 1'b1;
    #1;
    checks++; if (gnts() !== 3'b001) begin errors++; $display("FAIL stall_gnt0: got %b want 001", gnts()); end
    tick();
    req_i[0].req = 1'b0;
    #1;
    checks++; if (gnts() !== 3'b100 || req_o.addr !== a2) begin errors++; $display("FAIL stall_gnt2: gnt %b addr %h want 100 %h", gnts(), req_o.addr, a2); end
    tick();
    idle_inputs();
    #1;
    checks++; if (outstanding !== 2'd2) begin errors++; $display("FAIL stall_outst: got %0d want 2", outstanding); end
  endtask

  task automatic test_full();
    do_reset();
    set_req(0, $urandom, $urandom);
    set_req(1, $urandom, $urandom);
    resp_i.gnt = 1'b1;
    #1;
    checks++; if (gnts() !== 3'b001) begin errors++; $display("FAIL full_gnt_a: got %b want 001", gnts()); end
    tick();
    #1;
    checks++; if (gnts() !== 3'b010) begin errors++; $display("FAIL full_gnt_b: got %b want 010", gnts()); end
    tick();
    #1;
    checks++; if (req_o.req !== 1'b0 || gnts() !== 3'b000) begin errors++; $display("FAIL full_block: req %b gnt %b want 0 000", req_o.req, gnts()); end
    checks++; if (outstanding !== 2'd2) begin errors++; $display("FAIL full_outst: got %0d want 2", outstanding); end
    tick();
    resp_i.rvalid = 1'b1;
    resp_i.rdata  = $urandom;
    #1;
    checks++; if (req_o.req !== 1'b1 || gnts() !== 3'b001) begin errors++; $display("FAIL full_popgnt: req %b gnt %b want 1 001", req_o.req, gnts()); end
    checks++; if (rvs() !== 3'b001) begin errors++; $display("FAIL full_poprv: got %b want 001", rvs()); end
    tick();
    resp_i.rvalid = 1'b0;
    resp_i.gnt    = 1'b0;
    #1;
    checks++; if (outstanding !== 2'd2 || req_o.req !== 1'b0) begin errors++; $display("FAIL full_keep: outst %0d req %b want 2 0", outstanding, req_o.req); end
    idle_inputs();
  endtask

  task automatic test_spurious();
    do_reset();
    resp_i.rvalid = 1'b1;
    #1;
    checks++; if (rvs() !== 3'b000) begin errors++; $display("FAIL spur_rvalid: got %b want 000", rvs()); end
    tick();
    resp_i.rvalid = 1'b0;
    #1;
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL spur_err: got %b want 1", err); end
    tick();
    tick();
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL spur_sticky: got %b want 1", err); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL spur_clear: got %b want 0", err); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] a1, a2;
    do_reset();
    a1 = $urandom;
    a2 = $urandom;
    set_req(1, a1, $urandom);
    resp_i.gnt = 1'b1;
    #1;
    tick();
    set_req(2, a2, $urandom);
    resp_i.gnt = 1'b0;
    #1;
    checks++; if (req_o.addr !== a2 || outstanding !== 2'd1) begin errors++; $display("FAIL rmid_pre: addr %h outst %0d want %h 1", req_o.addr, outstanding, a2); end
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    checks++; if (outstanding !== 2'd0 || err !== 1'b0) begin errors++; $display("FAIL rmid_flush: outst %0d err %b want 0 0", outstanding, err); end
    checks++; if (req_o.req !== 1'b1 || req_o.addr !== a1) begin errors++; $display("FAIL rmid_rearb: req %b addr %h want 1 %h", req_o.req, req_o.addr, a1); end
    idle_inputs();
  endtask

  task automatic test_random();
    int           q[$];
    int           m_rr, m_lidx, msel;
    bit           m_locked, m_err, many, exp_req, full_eff;
    logic [N-1:0] exp_g, exp_rv;
    do_reset();
    m_rr = 0; m_locked = 0; m_lidx = 0; m_err = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int k = 0; k < N; k++)
        if (!req_i[k].req && ($urandom % 3 == 0)) set_req(k, $urandom, $urandom);
      resp_i.gnt    = ($urandom % 4 != 0);
      resp_i.rvalid = (q.size() > 0) && ($urandom % 3 == 0);
      resp_i.rdata  = $urandom;
      #1;
      // Reference: held selection while waiting for gnt, else first requester from rr.
      full_eff = (q.size() == MO) && !resp_i.rvalid;
      many = 0;
      msel = 0;
      if (m_locked) begin
        many = 1;
        msel = m_lidx;
      end else begin
        for (int i = 0; i < N; i++)
          if (!many && req_i[(m_rr + i) % N].req) begin
            many = 1;
            msel = (m_rr + i) % N;
          end
      end
      exp_req = many && !full_eff;
      exp_g   = '0;
      exp_rv  = '0;
      if (exp_req && resp_i.gnt) exp_g[msel] = 1'b1;
      if (resp_i.rvalid && q.size() > 0) exp_rv[q[0]] = 1'b1;
      checks++; if (req_o.req !== exp_req) begin errors++; $display("FAIL rand_req[%0d]: got %b want %b", cyc, req_o.req, exp_req); end
      if (exp_req) begin
        checks++; if (req_o.addr !== req_i[msel].addr || req_o.wdata !== req_i[msel].wdata
                      || req_o.be !== req_i[msel].be || req_o.we !== req_i[msel].we) begin
          errors++; $display("FAIL rand_mux[%0d]: addr %h want %h (sel %0d)", cyc, req_o.addr, req_i[msel].addr, msel);
        end
      end
      checks++; if (gnts() !== exp_g) begin errors++; $display("FAIL rand_gnt[%0d]: got %b want %b", cyc, gnts(), exp_g); end
      checks++; if (rvs() !== exp_rv) begin errors++; $display("FAIL rand_rvalid[%0d]: got %b want %b", cyc, rvs(), exp_rv); end
      checks++; if (outstanding !== 2'(q.size())) begin errors++; $display("FAIL rand_outst[%0d]: got %0d want %0d", cyc, outstanding, q.size()); end
      checks++; if (err !== m_err) begin errors++; $display("FAIL rand_err[%0d]: got %b want %b", cyc, err, m_err); end
      if (resp_i.rvalid) begin
        if (q.size() > 0) void'(q.pop_front());
        else m_err = 1;
      end
      if (exp_req && resp_i.gnt) begin
        q.push_back(msel);
        m_rr     = (msel + 1) % N;
        m_locked = 0;
      end else if (exp_req) begin
        m_locked = 1;
        m_lidx   = msel;
      end
      tick();
      for (int k = 0; k < N; k++) if (exp_g[k]) req_i[k].req = 1'b0;
    end
    idle_inputs();
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_single();
    test_rotate();
    test_stall();
    test_full();
    test_spurious();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
